busca_instrucao: RTL
====================

Name: busca_instrucao

Overview:
Instruction fetch controller that sequences the word-addressed, combinational-read instruction memory. Holds the program counter and drives the memory word address. Registers the returned instruction into a one-entry valid/ready output stage toward decode. Accepts branch redirects from execute and a halt request from the control unit.

Parameters:
BITS, 32, instruction width; equals instruction memory data width.
ADDR_W, 5, instruction memory word-address width.
RESET_PC, 32'h0000_0004, byte address fetched first after reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
mem_endr  output  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2], combinational from pc.
mem_dout  input  BITS  instruction memory read data; valid in the same cycle as mem_endr.
instr  output  BITS  registered instruction to decode.
instr_pc  output  32  byte address of instr.
instr_valid  output  1  instr/instr_pc hold a live instruction.
instr_ready  input  1  decode accepts instr this cycle.
redirect  input  1  branch taken; load redirect_pc and flush.
redirect_pc  input  32  branch target byte address.
halt  input  1  level request to stop fetching.
halted  output  1  high while in HALT.
misaligned  output  1  sticky flag: redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=BOOT, instr=0, instr_pc=0, instr_valid=0, halted=0, misaligned=0.
- States: BOOT, RUN, HALT, FAULT. State, pc and the output stage all update on the rising edge of clk.
- BOOT: lasts one cycle after reset release. No capture. Next state is RUN. A redirect during BOOT is applied with RUN-state rules.
- Load condition in RUN: load = !instr_valid || instr_ready.
- RUN, no redirect, load=1: instr<=mem_dout, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
- RUN, no redirect, load=0: hold all outputs and pc (stall).
- Throughput: one instruction per cycle while instr_ready=1. Latency from pc to instr_valid is 1 cycle.
- Redirect has highest priority, in any state except FAULT:
  - instr_valid<=0, flushing the held word even if instr_ready=1 that cycle.
  - pc<=redirect_pc; the next state is RUN.
  - First instruction from the target appears 2 cycles after the redirect edge.
- Misaligned redirect (redirect_pc[1:0]!=0): misaligned<=1, state<=FAULT, instr_valid<=0, pc<=redirect_pc.
- FAULT: no fetch, redirect ignored. Exit only via reset.
- Halt in RUN with no redirect:
  - If load=1, perform this cycle's capture, then go to HALT.
  - If load=0, stay in RUN until the held instruction is accepted, then go to HALT.
- HALT: halted=1, pc frozen, no capture.
  - A pending instr_valid remains until instr_ready, then clears to 0.
  - halt=0 returns to RUN the next cycle; fetch resumes at the frozen pc.
- Redirect and halt in the same cycle: the redirect is applied first, then the state goes to HALT. pc=redirect_pc, instr_valid=0.
- pc increments modulo 2^32. mem_endr is truncated, so fetch aliases modulo 2^(ADDR_W+2) bytes. No error is flagged for this wrap.
- reset_n asserted mid-stall or in HALT/FAULT: immediate return to reset values.

Test Plan:
- Reset with RESET_PC=4, memory word1=32'h01002103, word2=32'h00012423, instr_ready=1 -> after BOOT: instr=32'h01002103 with instr_pc=4, next cycle instr=32'h00012423 with instr_pc=8, one per cycle.
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=12 is valid -> instr, instr_pc and mem_endr stable. On ready=1, instr_pc=16 follows next cycle with no skipped or duplicated word.
- Redirect with redirect_pc=32 while instr_valid=1 and ready=1 -> next cycle instr_valid=0, mem_endr=8. Following cycle instr_pc=32, instr=word8 (32'h04210063).
- Misaligned redirect with redirect_pc=34 -> misaligned=1, instr_valid=0, FAULT. Later aligned redirects ignored until reset_n pulse clears the flag.
- Halt for 4 cycles with ready=0 -> held word delivered once ready=1, halted=1, pc frozen. halt=0 -> fetch resumes at the next sequential pc.
- pc=124 with ADDR_W=5 -> mem_endr=31, then pc=128 gives mem_endr=0 (alias wrap), instr_pc=128.

Source files
------------

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch controller driving a combinational-read
// instruction memory, with a one-entry valid/ready output stage toward decode.
module busca_instrucao #(
    parameter int          BITS     = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_endr,
    input  logic [BITS-1:0]   mem_dout,
    output logic [BITS-1:0]   instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic              misaligned
);
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [31:0]     pc_q, pc_d, ipc_q, ipc_d;
    logic [BITS-1:0] instr_q, instr_d;
    logic            valid_q, valid_d, mis_q, mis_d;
    logic            load;

    assign load = !valid_q || instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        if (state_q != FAULT && redirect) begin
            valid_d = 1'b0;
            pc_d    = redirect_pc;
            mis_d   = mis_q || (redirect_pc[1:0] != 2'b00);
            state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : (halt ? HALT : RUN);
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else if (state_q == RUN && load) begin
            instr_d = mem_dout;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = halt ? HALT : RUN;
        end else if (state_q == HALT) begin
            // pending word drains to decode, nothing new is captured
            valid_d = valid_q && !instr_ready;
            state_d = halt ? HALT : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ipc_q   <= 32'd0;
            instr_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign mem_endr    = pc_q[ADDR_W+1:2];
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);
    assign misaligned  = mis_q;
endmodule
